// File: rtl/io_pkg.sv
// Shared register map for the memory-mapped input peripheral.
// Offsets are word indices within the 16-byte window (Addr[3:2]).
package io_pkg;

   typedef enum logic [1:0] {
      OFF_DATA   = 2'd0,
      OFF_STATUS = 2'd1,
      OFF_CTRL   = 2'd2,
      OFF_RSVD   = 2'd3
   } reg_off_e;

   localparam int ST_EMPTY     = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_UF        = 2;
   localparam int ST_COUNT_LSB = 8;
   localparam int ST_COUNT_W   = 8;

   localparam int CTRL_FLUSH  = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int CTRL_CLR_UF = 2;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with flush; head is combinational so loads see it in the
// same cycle. Push when full and pop when empty are ignored internally.
module io_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic              i_flush,
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_head,
   output logic [CW-1:0]     o_count,
   output logic              o_empty,
   output logic              o_full
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              w_push;
   logic              w_pop;

   assign o_count = r_count;
   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_head  = r_mem[r_rd_ptr];
   assign w_push  = i_push & ~o_full & ~i_flush;
   assign w_pop   = i_pop & ~o_empty & ~i_flush;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours regardless of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; count/pointers guard every read,
   // so stale words are never observable and the array can map to plain RAM.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/io_input_interface.sv
// Bus responder for core loads/stores: DATA/STATUS/CTRL registers over an
// input FIFO fed by a valid/ready producer, with a level interrupt request.
module io_input_interface
   import io_pkg::*;
#(
   parameter int          DATA_W    = 32,
   parameter int          DEPTH     = 4,
   parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
   localparam int         CW        = $clog2(DEPTH) + 1
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [31:0]       Addr,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [DATA_W-1:0] WriteData,
   output logic [DATA_W-1:0] ReadData,
   output logic              Hit,
   input  logic              InValid,
   input  logic [DATA_W-1:0] InData,
   output logic              InReady,
   output logic              IrqPending
);

   reg_off_e          w_off;
   logic              w_rd;
   logic              w_wr;
   logic              w_ctrl_wr;
   logic              w_flush;
   logic              w_data_rd;
   logic              w_pop;
   logic              w_push;
   logic              w_empty;
   logic              w_full;
   logic [CW-1:0]     w_count;
   logic [DATA_W-1:0] w_head;
   logic              r_irq_en;
   logic              r_uf;
   logic              r_irq;

   assign Hit   = (Addr[31:4] == BASE_ADDR[31:4]);
   assign w_off = reg_off_e'(Addr[3:2]);

   // A simultaneous store wins: the load still returns data but has no side effect.
   assign w_rd      = Hit & MemRead & ~MemWrite;
   assign w_wr      = Hit & MemWrite;
   assign w_ctrl_wr = w_wr & (w_off == OFF_CTRL);
   assign w_flush   = w_ctrl_wr & WriteData[CTRL_FLUSH];
   assign w_data_rd = w_rd & (w_off == OFF_DATA);
   assign w_pop     = w_data_rd & ~w_empty;

   assign InReady = ~w_full & ~w_flush;
   assign w_push  = InValid & InReady;

   io_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (Clk),
      .rst_n   (Reset_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_data  (InData),
      .o_head  (w_head),
      .o_count (w_count),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_irq_en <= 1'b0;
         r_uf     <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         if (w_ctrl_wr) r_irq_en <= WriteData[CTRL_IRQ_EN];
         if (w_data_rd && w_empty)
            r_uf <= 1'b1;
         else if (w_ctrl_wr && WriteData[CTRL_CLR_UF])
            r_uf <= 1'b0;
         r_irq <= r_irq_en & ~w_empty;
      end
   end

   assign IrqPending = r_irq;

   // NOTE: ReadData gets a default before any branch, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      ReadData = '0;
      if (Hit && MemRead) begin
         case (w_off)
            OFF_DATA: begin
               if (!w_empty) ReadData = w_head;
            end
            OFF_STATUS: begin
               ReadData[ST_EMPTY]                      = w_empty;
               ReadData[ST_FULL]                       = w_full;
               ReadData[ST_UF]                         = r_uf;
               ReadData[ST_COUNT_LSB +: ST_COUNT_W]    = ST_COUNT_W'(w_count);
            end
            OFF_CTRL: begin
               ReadData[CTRL_IRQ_EN] = r_irq_en;
            end
            default: ReadData = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_io_input_interface.sv
// Scoreboard bench: the driver keeps a queue-based model of the peripheral and
// pushes per-cycle expectations; a monitor pops and compares at each negedge.
module tb_io_input_interface;

   localparam int          DATA_W = 32;
   localparam int          DEPTH  = 4;
   localparam logic [31:0] BASE   = 32'hFFFF_0000;

   logic              Clk = 1'b0;
   logic              Reset_n = 1'b0;
   logic [31:0]       Addr = '0;
   logic              MemRead = 1'b0;
   logic              MemWrite = 1'b0;
   logic [DATA_W-1:0] WriteData = '0;
   logic [DATA_W-1:0] ReadData;
   logic              Hit;
   logic              InValid = 1'b0;
   logic [DATA_W-1:0] InData = '0;
   logic              InReady;
   logic              IrqPending;

   io_input_interface #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .BASE_ADDR (BASE)
   ) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .Addr       (Addr),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .WriteData  (WriteData),
      .ReadData   (ReadData),
      .Hit        (Hit),
      .InValid    (InValid),
      .InData     (InData),
      .InReady    (InReady),
      .IrqPending (IrqPending)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      string       name;
      logic [31:0] rd;
      logic        hit;
      logic        rdy;
      logic        irq;
   } exp_t;

   exp_t        exp_q[$];
   int          total = 0;
   int          bad   = 0;

   // Reference model state: the FIFO contents as a plain queue.
   logic [31:0] m_q[$];
   bit          m_irq_en = 0;
   bit          m_uf     = 0;
   bit          m_irq    = 0;

   task automatic check(input string n, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", n, got, want);
      end
   endtask

   task automatic cyc(input string name, input bit mr, input bit mw,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input bit inv, input logic [31:0] ind);
      exp_t        e;
      bit          hit;
      bit          flush;
      bit          rdy;
      logic [1:0]  off;
      logic [31:0] rd;
      int          n;
      @(posedge Clk);
      #1;
      Reset_n   = 1'b1;
      Addr      = addr;
      MemRead   = mr;
      MemWrite  = mw;
      WriteData = wd;
      InValid   = inv;
      InData    = ind;
      hit   = (addr[31:4] == BASE[31:4]);
      off   = addr[3:2];
      n     = m_q.size();
      rd    = 32'h0;
      if (hit && mr) begin
         if (off == 2'd0)      rd = (n > 0) ? m_q[0] : 32'h0;
         else if (off == 2'd1) rd = (32'(n) << 8) | {29'b0, m_uf, n == DEPTH, n == 0};
         else if (off == 2'd2) rd = {30'b0, m_irq_en, 1'b0};
      end
      flush  = hit && mw && off == 2'd2 && wd[0];
      rdy    = (n < DEPTH) && !flush;
      e.name = name;
      e.rd   = rd;
      e.hit  = hit;
      e.rdy  = rdy;
      e.irq  = m_irq;
      exp_q.push_back(e);
      // State as it will be after the coming clock edge.
      m_irq = m_irq_en && (n > 0);
      if (hit && mw) begin
         if (off == 2'd2) begin
            if (wd[0]) m_q.delete();
            m_irq_en = wd[1];
            if (wd[2]) m_uf = 0;
         end
      end else if (hit && mr && off == 2'd0) begin
         if (n > 0) void'(m_q.pop_front());
         else       m_uf = 1;
      end
      if (inv && rdy) m_q.push_back(ind);
   endtask

   task automatic rd_reg(input string name, input int off);
      cyc(name, 1, 0, BASE + 32'(off * 4), 32'h0, 0, 32'h0);
   endtask

   task automatic wr_ctrl(input string name, input logic [31:0] wd);
      cyc(name, 0, 1, BASE + 32'h8, wd, 0, 32'h0);
   endtask

   task automatic push(input string name, input logic [31:0] d);
      cyc(name, 0, 0, 32'h0, 32'h0, 1, d);
   endtask

   task automatic idle(input string name);
      cyc(name, 0, 0, 32'h0, 32'h0, 0, 32'h0);
   endtask

   // Reset asserted between edges while STATUS is being read.
   task automatic rst_mid(input string name);
      exp_t e;
      @(posedge Clk);
      #1;
      Addr     = BASE + 32'h4;
      MemRead  = 1'b1;
      MemWrite = 1'b0;
      InValid  = 1'b1;
      InData   = 32'hEE;
      Reset_n  = 1'b0;
      e.name = name;
      e.rd   = 32'h1;
      e.hit  = 1'b1;
      e.rdy  = 1'b1;
      e.irq  = 1'b0;
      exp_q.push_back(e);
      m_q.delete();
      m_irq_en = 0;
      m_uf     = 0;
      m_irq    = 0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge Clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.name, " rdata"}, ReadData, e.rd);
            check({e.name, " hit"}, {31'b0, Hit}, {31'b0, e.hit});
            check({e.name, " inready"}, {31'b0, InReady}, {31'b0, e.rdy});
            check({e.name, " irq"}, {31'b0, IrqPending}, {31'b0, e.irq});
         end
      end
   end

   initial begin : driver
      repeat (2) @(posedge Clk);
      rd_reg("reset_status", 1);

      push("push_a1", 32'hA1);
      push("push_b2", 32'hB2);
      push("push_c3", 32'hC3);
      push("push_d4", 32'hD4);
      rd_reg("full_status", 1);
      for (int i = 0; i < 4; i++) rd_reg("drain_data", 0);
      rd_reg("drained_status", 1);

      rd_reg("underflow_data", 0);
      rd_reg("underflow_status", 1);
      wr_ctrl("clr_uf", 32'h4);
      rd_reg("uf_cleared_status", 1);

      wr_ctrl("irq_en", 32'h2);
      rd_reg("ctrl_read", 2);
      push("irq_push", 32'h55);
      idle("irq_wait1");
      idle("irq_wait2");
      rd_reg("irq_pop", 0);
      idle("irq_drop1");
      idle("irq_drop2");

      push("pp_fill1", 32'h11);
      push("pp_fill2", 32'h22);
      for (int i = 0; i < 10; i++)
         cyc("push_pop", 1, 0, BASE, 32'h0, 1, 32'h77 + 32'(i << 8));
      rd_reg("pp_status", 1);
      rd_reg("pp_drain", 0);
      rd_reg("pp_drain", 0);
      rd_reg("pp_empty_status", 1);

      push("fl_fill1", 32'h31);
      push("fl_fill2", 32'h32);
      push("fl_fill3", 32'h33);
      cyc("flush_vs_push", 0, 1, BASE + 32'h8, 32'h1, 1, 32'h99);
      rd_reg("flushed_status", 1);
      push("post_flush_push", 32'h42);
      rd_reg("post_flush_status", 1);
      cyc("rw_both", 1, 1, BASE, 32'h0, 0, 32'h0);
      cyc("rsvd_write", 0, 1, BASE + 32'hC, 32'h7, 0, 32'h0);
      rd_reg("rsvd_read", 3);
      push("burst1", 32'h61);
      push("burst2", 32'h62);
      rst_mid("reset_mid");
      rd_reg("after_reset_status", 1);

      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         logic [31:0] wd;
         if ($urandom_range(0, 99) < 8) a = 32'h1234_5670 | 32'($urandom_range(0, 15));
         else                          a = BASE + 32'($urandom_range(0, 3) * 4);
         wd = {29'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 7) == 0)};
         cyc("random", 1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0, a, wd,
             $urandom_range(0, 2) != 0, $urandom);
      end
      idle("tail");

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge Clk);
      #1;
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout got=%0d want=0 pending expectations", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/io_input_interface.md
Name: io_input_interface

Overview:
- Memory-mapped input peripheral ("interface entrada") that acts as the bus responder to the Mips32 core's load/store accesses.
- Accepts words from an external producer over a valid/ready handshake and buffers them in a small FIFO.
- Exposes DATA, STATUS and CTRL registers at a fixed base address and raises a level interrupt request while data is pending.

Parameters:
- DATA_W, 32, width of the external data word and of the CPU data bus.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- BASE_ADDR, 32'hFFFF_0000, byte address of register offset 0x0; the block decodes a 16-byte window.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Addr  in  32  CPU byte address.
- MemRead  in  1  CPU load strobe.
- MemWrite  in  1  CPU store strobe.
- WriteData  in  DATA_W  CPU store data.
- ReadData  out  DATA_W  load data; combinational from the current state.
- Hit  out  1  Addr is inside the window; the core muxes ReadData when this is high.
- InValid  in  1  producer holds valid data.
- InData  in  DATA_W  producer data.
- InReady  out  1  block can accept a word this cycle.
- IrqPending  out  1  registered interrupt request.

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-low on Reset_n; the polarity and synchronicity are fixed.
- Reset clears the FIFO (count 0), the irq_en bit and the underflow sticky bit, and drives IrqPending to 0. After reset, ReadData is 0 (no access in progress) and InReady is 1.
- Decode: Hit = (Addr[31:4] == BASE_ADDR[31:4]). Offset = Addr[3:2].
  - 0 = DATA (read-only)
  - 1 = STATUS (read-only)
  - 2 = CTRL (read/write)
  - 3 = reserved: reads 0, writes ignored.
- ReadData when Hit & MemRead, otherwise 0:
  - DATA: FIFO head word, or 0 if the FIFO is empty.
  - STATUS: bit0 empty, bit1 full, bit2 underflow, bits[15:8] count, rest 0.
  - CTRL: bit1 irq_en, rest 0.
- Pop: at the rising edge, if Hit & MemRead & offset DATA & !empty, advance the read pointer.
- Load latency: zero cycles, so the single-cycle core sees the data in the same cycle as its load.
- Underflow: a DATA read while empty sets the underflow bit (sticky), does not pop, and returns 0.
- CTRL write (Hit & MemWrite & offset 2) takes effect at the rising edge:
  - WriteData bit0 = flush: count 0, pointers 0.
  - WriteData bit1 is loaded into irq_en.
  - WriteData bit2 = 1 clears underflow.
  - bits 0 and 2 are self-clearing actions and are not stored.
- Writes to DATA or STATUS are ignored.
- Push: InReady = !full & !flush_now, where flush_now is a CTRL write with bit0 = 1 in the current cycle. At the edge, if InValid & InReady, write InData at the write pointer.
- Simultaneous push and pop: both take effect and count is unchanged.
  - When full, InReady is 0 even if a pop happens in the same cycle (no same-cycle pass-through).
- Flush and pop in the same cycle cannot occur, because a single access is either a read or a write. Flush wins over any push because InReady is held low.
- Pointer arithmetic:
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits, range 0..DEPTH.
  - empty = (count == 0); full = (count == DEPTH).
- IrqPending is registered: next value = irq_en & !empty, computed from post-edge state. It asserts one cycle after the first word lands while enabled.
- Reset mid-operation: state is discarded immediately (asynchronous), and InReady returns to 1 once Reset_n is released.
- MemRead and MemWrite both high in the same cycle: MemWrite is processed; the read returns data but no pop occurs.

Decomposition:
- Package io_pkg holds:
  - register offsets (OFF_DATA = 0, OFF_STATUS = 1, OFF_CTRL = 2);
  - STATUS bit positions;
  - CTRL bit positions (CTRL_FLUSH = 0, CTRL_IRQ_EN = 1, CTRL_CLR_UF = 2).
- Sub-module io_fifo: synchronous FIFO (DATA_W, DEPTH) with push, pop, flush, head, count, empty and full. The top level holds the decode, the register file, the handshake and the IRQ logic.

Test Plan:
- Reset, then read STATUS -> ReadData = 32'h0000_0001 (empty), InReady = 1, IrqPending = 0.
- Push 0xA1, 0xB2, 0xC3, 0xD4 -> STATUS = 0x0000_0402 (count 4, full), InReady = 0. Four DATA reads return A1, B2, C3, D4 in order, and the final STATUS is 0x0000_0001.
- Read DATA while empty -> ReadData = 0 and STATUS bit2 = 1. Write CTRL = 0x4, then STATUS bit2 = 0.
- Write CTRL = 0x2 (irq_en), then push 0x55 -> IrqPending = 1 one cycle after acceptance. Read DATA -> IrqPending = 0 on the next cycle.
- With count 2, hold InValid with 0x77 while reading DATA in the same cycle -> count stays 2, the popped word is the old head, and 0x77 emerges after the remaining entry. Wrap pointers by repeating this 10 times.
- With count 3, write CTRL = 0x1 while InValid is high -> InReady = 0 that cycle, STATUS reads empty afterwards, and the next push is accepted. Asserting Reset_n = 0 mid-burst clears the count with no clock edge.
